// File: rtl/instr_fetch_unit_pkg.sv
// Purpose : shared fetch-stage types and address constants for mips_cpu,
//           the instruction-fetch testbench and the RAM models.
// Contents: fetch_state_t, RESET_VECTOR_DEFAULT, HALT_ADDR_DEFAULT, pc_add().
package mips_fetch_pkg;

  // Fetch sequencer states. A redirect taken in RUN first presents the
  // delay slot (DELAY), then lands on the target, halts or faults.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

  // PC arithmetic is plain 32-bit unsigned and wraps modulo 2^32.
  function automatic logic [31:0] pc_add(input logic [31:0] base,
                                         input logic [31:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Purpose : combinational instruction-memory bus between the fetch unit and
//           the instruction RAM.
// Signals : instr_address (fetch side -> RAM), instr_readdata (RAM -> fetch).
interface instr_fetch_unit_if;

  logic [31:0] instr_address;
  logic [31:0] instr_readdata;

  // Fetch unit drives the address and consumes the returned word.
  modport master (
    output instr_address,
    input  instr_readdata
  );

  // Instruction RAM answers the address in the same cycle.
  modport slave (
    input  instr_address,
    output instr_readdata
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose : owns the PC, fetches from instruction RAM and sequences MIPS
//           branch delay slots; halts on a redirect to HALT_ADDR.
// Ports   : clk, reset (sync, active-high), clk_enable (0 = full stall),
//           redirect_valid/redirect_target from decode, imem (master side of
//           the instruction-memory bus), instr/pc/pc_plus8 to decode,
//           in_delay_slot/active/fault status.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_enable,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_target,
  instr_fetch_unit_if.master          imem,
  output logic [31:0]                 instr,
  output logic [31:0]                 pc,
  output logic [31:0]                 pc_plus8,
  output logic                        in_delay_slot,
  output logic                        active,
  output logic                        fault
);

  // State codes kept as plain 2-bit constants so the register can be
  // probed and compared without enum casts.
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_DELAY  = DELAY;
  localparam logic [1:0] ST_HALTED = HALTED;
  localparam logic [1:0] ST_FAULT  = FAULT;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic [1:0]  state_q, state_d;

  logic [31:0] pc_seq;
  logic        pending_is_halt;
  logic        pending_misaligned;

  assign pc_seq             = pc_add(pc_q, 32'd4);
  assign pending_is_halt    = (pending_q == HALT_ADDR);
  assign pending_misaligned = (pending_q[1:0] != 2'b00);

  // Next-state logic. With clk_enable low everything holds and redirects
  // are dropped. HALTED and FAULT are sticky until reset.
  always_comb begin
    pc_d      = pc_q;
    pending_d = pending_q;
    state_d   = state_q;
    if (clk_enable) begin
      case (state_q)
        ST_RUN: begin
          // The sequential successor is the delay slot when a redirect is
          // taken, so pc always advances by 4 here.
          pc_d = pc_seq;
          if (redirect_valid) begin
            pending_d = redirect_target;
            state_d   = ST_DELAY;
          end
        end
        ST_DELAY: begin
          // A branch sitting in the delay slot is ignored. Alignment is
          // only judged here, after the delay slot has been presented.
          if (pending_is_halt) begin
            pc_d    = HALT_ADDR;
            state_d = ST_HALTED;
          end else if (pending_misaligned) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = pending_q;
            state_d = ST_RUN;
          end
        end
        default: begin
          // ST_HALTED / ST_FAULT: hold.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_VECTOR;
      pending_q <= 32'h0;
      state_q   <= ST_RUN;
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      state_q   <= state_d;
    end
  end

  // Outputs come straight from registered state; the RAM is combinational
  // so there is no extra fetch latency.
  assign imem.instr_address = pc_q;
  assign pc                 = pc_q;
  assign pc_plus8           = pc_add(pc_q, 32'd8);
  assign active             = (state_q == ST_RUN) || (state_q == ST_DELAY);
  assign fault              = (state_q == ST_FAULT);
  assign in_delay_slot      = (state_q == ST_DELAY);
  // A stopped core feeds nops (all-zero word) into decode.
  assign instr              = active ? imem.instr_readdata : 32'h0;

endmodule
